// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for the MIPS-subset datapath: fetch/decode/execute sequencing with Moore outputs.
// Optional performance counters are enabled by defining MC_CTRL_PERF_CNT_EN.
module mc_ctrl #(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       overflow,
    input  logic       positive,
    output logic [1:0] alu_ctl,
    output logic       ext_op,
    output logic [1:0] reg_src,
    output logic [1:0] reg_dst,
    output logic       alu_src,
    output logic       npc_sel,
    output logic       j_ctl,
    output logic       jr_ctl,
    output logic       mem_write,
    output logic       reg_write,
    output logic       ir_we,
    output logic       pc_we,
    output logic       halted
`ifdef MC_CTRL_PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt
`endif
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXE, S_MEM_RD, S_MEM_WR,
        S_WB, S_BRANCH, S_JUMP, S_NOP, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        C_ADDU, C_SUBU, C_JR, C_ORI, C_LUI, C_ADDI,
        C_LW, C_SW, C_BEQ, C_J, C_JAL, C_ILL
    } cls_t;

    state_t state_r;
    state_t state_nxt_s;
    cls_t   cls_r;
    cls_t   dec_cls_s;
    logic   ovf_r;
    logic   positive_unused_r;

    logic [1:0] alu_ctl_s;
    logic       ext_op_s;
    logic [1:0] reg_src_s;
    logic [1:0] reg_dst_s;
    logic       alu_src_s;
    logic       npc_sel_s;
    logic       j_ctl_s;
    logic       jr_ctl_s;
    logic       mem_write_s;
    logic       reg_write_s;
    logic       ir_we_s;
    logic       pc_we_s;
    logic       halted_s;

    function automatic cls_t classify(input logic [5:0] op, input logic [5:0] fn);
        cls_t c;
        case (op)
            6'b000000: begin
                case (fn)
                    6'b100001: c = C_ADDU;
                    6'b100011: c = C_SUBU;
                    6'b001000: c = C_JR;
                    default:   c = C_ILL;
                endcase
            end
            6'b001101: c = C_ORI;
            6'b001111: c = C_LUI;
            6'b001000: c = C_ADDI;
            6'b100011: c = C_LW;
            6'b101011: c = C_SW;
            6'b000100: c = C_BEQ;
            6'b000010: c = C_J;
            6'b000011: c = C_JAL;
            default:   c = C_ILL;
        endcase
        return c;
    endfunction

    function automatic logic sign_ext(input cls_t c);
        return (c == C_ADDI) || (c == C_LW) || (c == C_SW) || (c == C_BEQ);
    endfunction

    // {alu_ctl, alu_src} used by EXE and held through the memory/writeback states
    function automatic logic [2:0] alu_cfg(input cls_t c);
        logic [2:0] r;
        case (c)
            C_ADDU:  r = 3'b000;
            C_SUBU:  r = 3'b010;
            C_ORI:   r = 3'b101;
            C_LUI:   r = 3'b111;
            C_ADDI:  r = 3'b001;
            C_LW:    r = 3'b001;
            C_SW:    r = 3'b001;
            default: r = 3'b000;
        endcase
        return r;
    endfunction

    assign dec_cls_s = classify(opcode, funct);

    // State, latched instruction class, and overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r           <= S_FETCH;
            cls_r             <= C_ILL;
            ovf_r             <= 1'b0;
            positive_unused_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (state_r == S_DECODE) begin
                cls_r <= dec_cls_s;
            end
            if (state_r == S_EXE) begin
                positive_unused_r <= positive;
                if (cls_r == C_ADDI) begin
                    ovf_r <= overflow;
                end
            end
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_FETCH:  state_nxt_s = S_DECODE;
            S_DECODE: begin
                case (dec_cls_s)
                    C_ADDU, C_SUBU, C_ORI, C_LUI,
                    C_ADDI, C_LW, C_SW:      state_nxt_s = S_EXE;
                    C_BEQ:                   state_nxt_s = S_BRANCH;
                    C_J, C_JAL, C_JR:        state_nxt_s = S_JUMP;
                    default:                 state_nxt_s = HALT_ON_ILLEGAL ? S_HALT : S_NOP;
                endcase
            end
            S_EXE: begin
                case (cls_r)
                    C_LW:    state_nxt_s = S_MEM_RD;
                    C_SW:    state_nxt_s = S_MEM_WR;
                    default: state_nxt_s = S_WB;
                endcase
            end
            S_MEM_RD: state_nxt_s = S_WB;
            S_MEM_WR: state_nxt_s = S_FETCH;
            S_WB:     state_nxt_s = S_FETCH;
            S_BRANCH: state_nxt_s = S_FETCH;
            S_JUMP:   state_nxt_s = S_FETCH;
            S_NOP:    state_nxt_s = S_FETCH;
            S_HALT:   state_nxt_s = S_HALT;
            default:  state_nxt_s = S_FETCH;
        endcase
    end

    // Moore control decode from state and latched class
    always_comb begin
        alu_ctl_s   = 2'b00;
        ext_op_s    = 1'b0;
        reg_src_s   = 2'b00;
        reg_dst_s   = 2'b00;
        alu_src_s   = 1'b0;
        npc_sel_s   = 1'b0;
        j_ctl_s     = 1'b0;
        jr_ctl_s    = 1'b0;
        mem_write_s = 1'b0;
        reg_write_s = 1'b0;
        ir_we_s     = 1'b0;
        pc_we_s     = 1'b0;
        halted_s    = 1'b0;
        case (state_r)
            S_FETCH:  ir_we_s  = 1'b1;
            S_DECODE: ext_op_s = sign_ext(dec_cls_s);
            S_EXE, S_MEM_RD: begin
                {alu_ctl_s, alu_src_s} = alu_cfg(cls_r);
                ext_op_s               = sign_ext(cls_r);
            end
            S_MEM_WR: begin
                {alu_ctl_s, alu_src_s} = alu_cfg(cls_r);
                ext_op_s               = sign_ext(cls_r);
                mem_write_s            = 1'b1;
                pc_we_s                = 1'b1;
            end
            S_WB: begin
                {alu_ctl_s, alu_src_s} = alu_cfg(cls_r);
                ext_op_s               = sign_ext(cls_r);
                reg_write_s            = 1'b1;
                pc_we_s                = 1'b1;
                if ((cls_r == C_ADDU) || (cls_r == C_SUBU)) begin
                    reg_dst_s = 2'b01;
                end else if ((cls_r == C_ADDI) && ovf_r) begin
                    // Overflowing addi leaves rt alone and flags $30 <- 1
                    reg_dst_s = 2'b10;
                    reg_src_s = 2'b10;
                end else if (cls_r == C_LW) begin
                    reg_src_s = 2'b01;
                end else begin
                    reg_dst_s = 2'b00;
                end
            end
            S_BRANCH: begin
                alu_ctl_s = 2'b01;
                ext_op_s  = sign_ext(cls_r);
                npc_sel_s = 1'b1;
                pc_we_s   = 1'b1;
            end
            S_JUMP: begin
                pc_we_s = 1'b1;
                case (cls_r)
                    C_J:     j_ctl_s = 1'b1;
                    C_JAL: begin
                        j_ctl_s     = 1'b1;
                        reg_write_s = 1'b1;
                        reg_dst_s   = 2'b11;
                        reg_src_s   = 2'b11;
                    end
                    C_JR:    jr_ctl_s = 1'b1;
                    default: j_ctl_s  = 1'b0;
                endcase
            end
            S_NOP:   pc_we_s  = 1'b1;
            S_HALT:  halted_s = 1'b1;
            default: ir_we_s  = 1'b0;
        endcase
    end

    // Reset masks every control so an interrupted instruction commits nothing
    assign {alu_ctl, ext_op, reg_src, reg_dst, alu_src, npc_sel, j_ctl, jr_ctl,
            mem_write, reg_write, ir_we, pc_we, halted} =
           rst ? 16'd0 :
           {alu_ctl_s, ext_op_s, reg_src_s, reg_dst_s, alu_src_s, npc_sel_s, j_ctl_s,
            jr_ctl_s, mem_write_s, reg_write_s, ir_we_s, pc_we_s, halted_s};

`ifdef MC_CTRL_PERF_CNT_EN
    // Cycle and retired-instruction counters, wrapping at 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt <= 32'd0;
            instr_cnt <= 32'd0;
        end else begin
            if (state_r != S_HALT) begin
                cycle_cnt <= cycle_cnt + 32'd1;
            end
            if (pc_we_s) begin
                instr_cnt <= instr_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle control FSM that sequences the single-cycle MIPS-subset datapath one instruction at a time.
- Decodes `opcode`/`funct` from the datapath and drives every datapath control input.
- Adds `ir_we` (latch instruction) and `pc_we` (commit next PC) strobes for the multi-cycle IFU, so GPR, DM and PC state update only in the final state of each instruction.

Parameters:
- HALT_ON_ILLEGAL, 1, 1 = an unknown opcode/funct enters HALT; 0 = it is treated as a NOP.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  6  instruction[31:26] from datapath
- funct  in  6  instruction[5:0] from datapath
- overflow  in  1  ALU signed overflow
- positive  in  1  ALU result > 0 (unused in base ISA; sampled for future use)
- alu_ctl  out  2  00 ADD, 01 SUB, 10 OR, 11 LUI
- ext_op  out  1  0 zero-extend, 1 sign-extend
- reg_src  out  2  00 ALU, 01 DM, 10 constant 1, 11 NPC
- reg_dst  out  2  00 rt, 01 rd, 10 $30, 11 $31
- alu_src  out  1  0 rt data, 1 ext imm
- npc_sel  out  1  1 = branch target if zero
- j_ctl  out  1  jump target select
- jr_ctl  out  1  jump-register select
- mem_write  out  1  DM write strobe
- reg_write  out  1  GPR write strobe
- ir_we  out  1  instruction register load
- pc_we  out  1  PC update strobe
- halted  out  1  FSM in HALT

Behaviour:
- Reset:
  - State = FETCH, internal ovf_q = 0.
  - While rst = 1, all outputs are forced to 0, including ir_we and halted.
- Output timing: all outputs are Moore, decoded from state plus the instruction class latched in DECODE. Any control not listed for a state is 0.
- ISA: addu, subu, jr (opcode 000000, funct 100001 / 100011 / 001000), ori 001101, lui 001111, addi 001000, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.
- FETCH: ir_we = 1. Next state is DECODE.
- DECODE:
  - Classify the instruction and drive ext_op for it: 1 for addi/lw/sw/beq, 0 otherwise.
  - Next state: EXE for R-ALU/ori/lui/addi/lw/sw, BRANCH for beq, JUMP for j/jal/jr.
  - Illegal instruction: HALT if HALT_ON_ILLEGAL = 1, otherwise NOP.
- EXE: ALU controls per class:
  - addu: alu_ctl = 00, alu_src = 0.
  - subu: alu_ctl = 01, alu_src = 0.
  - ori: alu_ctl = 10, alu_src = 1.
  - lui: alu_ctl = 11, alu_src = 1.
  - addi/lw/sw: alu_ctl = 00, alu_src = 1.
  - ovf_q ← overflow, addi only.
  - Next state: MEM_RD for lw, MEM_WR for sw, WB otherwise.
- MEM_RD: hold the EXE ALU controls. Next state is WB.
- MEM_WR: hold the EXE ALU controls. mem_write = 1, pc_we = 1. Next state is FETCH.
- WB:
  - Hold ALU controls and assert reg_write = 1, pc_we = 1.
  - R-type: reg_dst = 01.
  - All other classes: reg_dst = 00.
  - reg_src = 01 for lw, 00 otherwise.
  - addi with ovf_q = 1: reg_dst = 10, reg_src = 10, so rt is not written and $30 ← 1.
  - Next state is FETCH.
- BRANCH: alu_ctl = 01, alu_src = 0, npc_sel = 1, pc_we = 1. Next state is FETCH.
- JUMP: pc_we = 1.
  - j: j_ctl = 1.
  - jal: j_ctl = 1, reg_write = 1, reg_dst = 11, reg_src = 11.
  - jr: jr_ctl = 1.
  - Next state is FETCH.
- NOP: pc_we = 1. Next state is FETCH.
- HALT: halted = 1, all strobes 0. Stays in HALT until rst.
- Latency (cycles per instruction): R/ori/lui/addi 4, lw 5, sw 4, beq/j/jal/jr 3, NOP 3.
- Exactly one pc_we pulse per retired instruction. reg_write and mem_write are never both 1 in the same cycle.
- rst asserted in any state: next state is FETCH and no strobe fires in that cycle. A partially executed instruction has no architectural effect.

Optional Feature:
- Macro: MC_CTRL_PERF_CNT_EN.
- Defined:
  - Adds outputs cycle_cnt[31:0] and instr_cnt[31:0], both cleared by rst.
  - cycle_cnt increments every non-HALT cycle.
  - instr_cnt increments on each pc_we.
  - Both wrap from 0xFFFFFFFF to 0.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- rst = 1 for 2 cycles, then release → all outputs 0 during reset; ir_we = 1 in the first cycle after release; state FETCH.
- addu (opcode 0, funct 100001) → ir_we, then DECODE, then EXE with alu_ctl = 00, alu_src = 0; WB in cycle 4 with reg_write = 1, reg_dst = 01, reg_src = 00, pc_we = 1.
- lw (100011) → 5 cycles; mem_write never 1; WB has reg_src = 01, reg_dst = 00, ext_op = 1. Then sw (101011) → mem_write = 1 and pc_we = 1 in cycle 4, reg_write = 0 throughout.
- addi with overflow = 1 in EXE → WB has reg_dst = 10, reg_src = 10, reg_write = 1. Repeat with overflow = 0 → reg_dst = 00, reg_src = 00.
- jal (000011) → cycle 3 has j_ctl = 1, reg_write = 1, reg_dst = 11, reg_src = 11, pc_we = 1. jr → jr_ctl = 1, reg_write = 0. beq → npc_sel = 1, alu_ctl = 01 in cycle 3.
- opcode 111111:
  - HALT_ON_ILLEGAL = 1 → halted = 1 from cycle 3 and held 10 cycles with pc_we = 0.
  - HALT_ON_ILLEGAL = 0 → pc_we = 1 in cycle 3, then FETCH.
  - rst mid-WB → reg_write = 0 that cycle.
  - With MC_CTRL_PERF_CNT_EN → instr_cnt = 1 and cycle_cnt = 3 after one j.
